// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants and small helpers used by the register file.
package cpu_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned REG_CNT  = 32;
  localparam int unsigned REG_ZERO = 0;

  // True when idx is the hardwired zero register and that feature is enabled.
  function automatic logic is_zero_reg(input int unsigned zero_reg, input int unsigned idx);
    return (zero_reg != 0) && (idx == REG_ZERO);
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: register select, write-to-read bypass and operand-ready logic.
module regfile_rd_port
  import cpu_pkg::*;
#(
  parameter int unsigned DW       = DATA_W,
  parameter int unsigned DEPTH    = REG_CNT,
  parameter int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                  rst,
  input  logic [AW-1:0]         rd_addr,
  input  logic [1:0]            wr_en,
  input  logic [2*AW-1:0]       wr_addr,
  input  logic [2*DW-1:0]       wr_data,
  input  logic [DEPTH*DW-1:0]   regs,
  input  logic [DEPTH-1:0]      pending,
  output logic [DW-1:0]         data,
  output logic                  ready
);

  logic [DW-1:0] stored;
  logic          stored_pend;
  logic          in_range;
  logic          is_zero;
  logic          hit0;
  logic          hit1;

  // Loop-based select only ever touches implemented registers, so no X from unused codes.
  always_comb begin
    stored      = '0;
    stored_pend = 1'b0;
    in_range    = 1'b0;
    for (int unsigned r = 0; r < DEPTH; r++) begin
      if (rd_addr == AW'(r)) begin
        stored      = regs[r*DW +: DW];
        stored_pend = pending[r];
        in_range    = 1'b1;
      end
    end
  end

  // Bypass is suppressed during reset so every read returns the cleared state.
  always_comb begin
    is_zero = (ZERO_REG != 0) && (rd_addr == AW'(REG_ZERO));
    hit1    = !rst && wr_en[1] && (wr_addr[AW +: AW] == rd_addr);
    hit0    = !rst && wr_en[0] && (wr_addr[0 +: AW] == rd_addr);
  end

  always_comb begin
    data = stored;
    if (is_zero || !in_range) begin
      data = '0;
    end else if (hit1) begin
      data = wr_data[DW +: DW];
    end else if (hit0) begin
      data = wr_data[0 +: DW];
    end
  end

  always_comb begin
    ready = !stored_pend || hit1 || hit0 || is_zero || !in_range;
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with two prioritised write ports, read bypass and a pending scoreboard.
module regfile_mp
  import cpu_pkg::*;
#(
  parameter int unsigned DW       = DATA_W,
  parameter int unsigned DEPTH    = REG_CNT,
  parameter int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_RD*AW-1:0] rd_addr,
  output logic [NUM_RD*DW-1:0] rd_data,
  output logic [NUM_RD-1:0]    rd_ready,
  input  logic [1:0]           wr_en,
  input  logic [2*AW-1:0]      wr_addr,
  input  logic [2*DW-1:0]      wr_data,
  input  logic                 pend_set,
  input  logic [AW-1:0]        pend_addr,
  output logic                 any_pending
);

  logic [DEPTH*DW-1:0] regs_q;
  logic [DEPTH-1:0]    pend_q;
  logic [DEPTH-1:0]    wr_hit0;
  logic [DEPTH-1:0]    wr_hit1;
  logic [DEPTH-1:0]    set_hit;

  // Per-register decode; the zero register never decodes, so it stays 0 and never pends.
  always_comb begin
    wr_hit0 = '0;
    wr_hit1 = '0;
    set_hit = '0;
    for (int unsigned r = 0; r < DEPTH; r++) begin
      if (!is_zero_reg(ZERO_REG, r)) begin
        wr_hit0[r] = wr_en[0] && (wr_addr[0 +: AW] == AW'(r));
        wr_hit1[r] = wr_en[1] && (wr_addr[AW +: AW] == AW'(r));
        set_hit[r] = pend_set && (pend_addr == AW'(r));
      end
    end
  end

  // Port 1 wins data collisions; a new producer's set beats a same-cycle writeback clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q <= '0;
      pend_q <= '0;
    end else begin
      for (int unsigned r = 0; r < DEPTH; r++) begin
        if (wr_hit1[r]) begin
          regs_q[r*DW +: DW] <= wr_data[DW +: DW];
        end else if (wr_hit0[r]) begin
          regs_q[r*DW +: DW] <= wr_data[0 +: DW];
        end
        if (set_hit[r]) begin
          pend_q[r] <= 1'b1;
        end else if (wr_hit0[r] || wr_hit1[r]) begin
          pend_q[r] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    any_pending = |pend_q;
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    regfile_rd_port #(
      .DW       (DW),
      .DEPTH    (DEPTH),
      .AW       (AW),
      .ZERO_REG (ZERO_REG)
    ) u_rd_port (
      .rst     (rst),
      .rd_addr (rd_addr[i*AW +: AW]),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .regs    (regs_q),
      .pending (pend_q),
      .data    (rd_data[i*DW +: DW]),
      .ready   (rd_ready[i])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: reset, writes, bypass, zero register, scoreboard, async reset.
module tb_regfile_mp;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 2;

  logic              clk;
  logic              rst;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data;
  logic [NR-1:0]     rd_ready;
  logic [1:0]        wr_en;
  logic [2*AW-1:0]   wr_addr;
  logic [2*DW-1:0]   wr_data;
  logic              pend_set;
  logic [AW-1:0]     pend_addr;
  logic              any_pending;

  int errors = 0;
  int checks = 0;

  regfile_mp #(.DW(DW), .DEPTH(32), .NUM_RD(NR), .ZERO_REG(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_ready    (rd_ready),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .pend_set    (pend_set),
    .pend_addr   (pend_addr),
    .any_pending (any_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en    = 2'b00;
    pend_set = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    rd_addr = '0; wr_addr = '0; wr_data = '0; pend_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (any_pending !== 1'b0) begin
      errors++; $display("FAIL reset_pending_in_rst: got %b want 0", any_pending);
    end
    rst = 1'b0;
    #1;
    for (int a = 0; a < 32; a++) begin
      rd_addr[0 +: AW] = AW'(a);
      rd_addr[AW +: AW] = AW'(31 - a);
      #1;
      checks++;
      if (rd_data !== '0) begin
        errors++; $display("FAIL reset_data a=%0d: got %h want 0", a, rd_data);
      end
      checks++;
      if (rd_ready !== 2'b11) begin
        errors++; $display("FAIL reset_ready a=%0d: got %b want 11", a, rd_ready);
      end
    end
    checks++;
    if (any_pending !== 1'b0) begin
      errors++; $display("FAIL reset_pending: got %b want 0", any_pending);
    end
  endtask

  task automatic test_write();
    wr_en = 2'b01; wr_addr[0 +: AW] = 5'd5; wr_data[0 +: DW] = 32'hDEADBEEF;
    tick(); idle();
    rd_addr[0 +: AW] = 5'd5;
    #1;
    checks++;
    if (rd_data[0 +: DW] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL write_basic: got %h want deadbeef", rd_data[0 +: DW]);
    end
    wr_en = 2'b11;
    wr_addr = {5'd7, 5'd7};
    wr_data = {32'h2, 32'h1};
    tick(); idle();
    rd_addr = {5'd5, 5'd7};
    #1;
    checks++;
    if (rd_data[0 +: DW] !== 32'h2) begin
      errors++; $display("FAIL write_same_addr: got %h want 2", rd_data[0 +: DW]);
    end
    checks++;
    if (rd_data[DW +: DW] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL write_keep5: got %h want deadbeef", rd_data[DW +: DW]);
    end
  endtask

  task automatic test_bypass();
    wr_en = 2'b01; wr_addr[0 +: AW] = 5'd9; wr_data[0 +: DW] = 32'h12345678;
    rd_addr = {5'd9, 5'd9};
    #1;
    checks++;
    if (rd_data[0 +: DW] !== 32'h12345678) begin
      errors++; $display("FAIL bypass_p0: got %h want 12345678", rd_data[0 +: DW]);
    end
    tick(); idle();
    checks++;
    if (rd_data[DW +: DW] !== 32'h12345678) begin
      errors++; $display("FAIL bypass_persist: got %h want 12345678", rd_data[DW +: DW]);
    end
    wr_en = 2'b11;
    wr_addr = {5'd10, 5'd10};
    wr_data = {32'hBBBB0001, 32'hAAAA0001};
    rd_addr = {5'd9, 5'd10};
    #1;
    checks++;
    if (rd_data[0 +: DW] !== 32'hBBBB0001) begin
      errors++; $display("FAIL bypass_prio: got %h want bbbb0001", rd_data[0 +: DW]);
    end
    checks++;
    if (rd_data[DW +: DW] !== 32'h12345678) begin
      errors++; $display("FAIL bypass_nohit: got %h want 12345678", rd_data[DW +: DW]);
    end
    tick(); idle();
    checks++;
    if (rd_data[0 +: DW] !== 32'hBBBB0001) begin
      errors++; $display("FAIL bypass_prio_store: got %h want bbbb0001", rd_data[0 +: DW]);
    end
  endtask

  task automatic test_zero();
    wr_en = 2'b01; wr_addr[0 +: AW] = 5'd0; wr_data[0 +: DW] = 32'hFFFFFFFF;
    pend_set = 1'b1; pend_addr = 5'd0;
    rd_addr = {5'd0, 5'd0};
    #1;
    checks++;
    if (rd_data[0 +: DW] !== 32'h0) begin
      errors++; $display("FAIL zero_bypass: got %h want 0", rd_data[0 +: DW]);
    end
    tick(); idle();
    checks++;
    if (rd_data[0 +: DW] !== 32'h0) begin
      errors++; $display("FAIL zero_data: got %h want 0", rd_data[0 +: DW]);
    end
    checks++;
    if (rd_ready !== 2'b11) begin
      errors++; $display("FAIL zero_ready: got %b want 11", rd_ready);
    end
    checks++;
    if (any_pending !== 1'b0) begin
      errors++; $display("FAIL zero_pending: got %b want 0", any_pending);
    end
  endtask

  task automatic test_scoreboard();
    pend_set = 1'b1; pend_addr = 5'd3;
    tick(); idle();
    rd_addr = {5'd5, 5'd3};
    #1;
    checks++;
    if (rd_ready !== 2'b10) begin
      errors++; $display("FAIL sb_ready_pend: got %b want 10", rd_ready);
    end
    checks++;
    if (any_pending !== 1'b1) begin
      errors++; $display("FAIL sb_any_set: got %b want 1", any_pending);
    end
    wr_en = 2'b01; wr_addr[0 +: AW] = 5'd3; wr_data[0 +: DW] = 32'hAA;
    #1;
    checks++;
    if (rd_ready[0] !== 1'b1 || rd_data[0 +: DW] !== 32'hAA) begin
      errors++; $display("FAIL sb_bypass_ready: got %b/%h want 1/aa", rd_ready[0], rd_data[0 +: DW]);
    end
    tick(); idle();
    checks++;
    if (rd_ready[0] !== 1'b1 || any_pending !== 1'b0) begin
      errors++; $display("FAIL sb_cleared: got %b/%b want 1/0", rd_ready[0], any_pending);
    end
    pend_set = 1'b1; pend_addr = 5'd4;
    wr_en = 2'b10; wr_addr[AW +: AW] = 5'd4; wr_data[DW +: DW] = 32'h44;
    tick(); idle();
    rd_addr = {5'd4, 5'd3};
    #1;
    checks++;
    if (rd_ready[1] !== 1'b0 || any_pending !== 1'b1) begin
      errors++; $display("FAIL sb_set_wins: got %b/%b want 0/1", rd_ready[1], any_pending);
    end
    checks++;
    if (rd_data[DW +: DW] !== 32'h44) begin
      errors++; $display("FAIL sb_set_wins_data: got %h want 44", rd_data[DW +: DW]);
    end
    wr_en = 2'b01; wr_addr[0 +: AW] = 5'd4; wr_data[0 +: DW] = 32'h45;
    tick(); idle();
    checks++;
    if (rd_ready[1] !== 1'b1 || any_pending !== 1'b0) begin
      errors++; $display("FAIL sb_clear4: got %b/%b want 1/0", rd_ready[1], any_pending);
    end
  endtask

  task automatic test_async_reset();
    pend_set = 1'b1; pend_addr = 5'd3;
    wr_en = 2'b01; wr_addr[0 +: AW] = 5'd5; wr_data[0 +: DW] = 32'h55;
    tick(); idle();
    rd_addr = {5'd3, 5'd5};
    #1;
    checks++;
    if (any_pending !== 1'b1 || rd_data[0 +: DW] !== 32'h55) begin
      errors++; $display("FAIL arst_pre: got %b/%h want 1/55", any_pending, rd_data[0 +: DW]);
    end
    wr_en = 2'b01; wr_addr[0 +: AW] = 5'd6; wr_data[0 +: DW] = 32'h66;
    rd_addr = {5'd3, 5'd6};
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (rd_data !== '0) begin
      errors++; $display("FAIL arst_data: got %h want 0", rd_data);
    end
    checks++;
    if (rd_ready !== 2'b11 || any_pending !== 1'b0) begin
      errors++; $display("FAIL arst_ready: got %b/%b want 11/0", rd_ready, any_pending);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
    rd_addr = {5'd5, 5'd6};
    #1;
    checks++;
    if (rd_data !== '0) begin
      errors++; $display("FAIL arst_after: got %h want 0", rd_data);
    end
    rd_addr = {5'd3, 5'd3};
    #1;
    checks++;
    if (rd_ready !== 2'b11 || any_pending !== 1'b0) begin
      errors++; $display("FAIL arst_after_pend: got %b/%b want 11/0", rd_ready, any_pending);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_bypass();
    test_zero();
    test_scoreboard();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file for the single-cycle and upcoming pipelined CPU datapaths.
- Provides NUM_RD combinational read ports and two prioritised write ports, with same-cycle write-to-read bypass.
- Includes a per-register pending scoreboard so the pipeline can stall on operands whose producers have not yet written back.
- Optionally hardwires register 0 to zero, as the MIPS-style ISA requires.

Parameters:
- DW, 32, data width in bits.
- DEPTH, 32, number of architectural registers; need not be a power of 2.
- AW, $clog2(DEPTH), address width; derived, never overridden.
- NUM_RD, 2, number of read ports.
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and is never pending.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- rd_addr  input  NUM_RD*AW  read addresses, port i in bits [i*AW +: AW].
- rd_data  output  NUM_RD*DW  read data, port i in bits [i*DW +: DW].
- rd_ready  output  NUM_RD  1 = port i data is architecturally valid this cycle.
- wr_en  input  2  write enables for ports 0 and 1.
- wr_addr  input  2*AW  write addresses.
- wr_data  input  2*DW  write data.
- pend_set  input  1  marks pend_addr as awaiting a writeback.
- pend_addr  input  AW  register to mark pending.
- any_pending  output  1  OR of all pending bits.

Behaviour:
- Reset: asynchronous and active-high; clock is clk. While rst=1, all DEPTH registers = 0 and all pending bits = 0.
  - Outputs during reset: rd_data = 0 for every address, rd_ready = all 1, any_pending = 0.
  - Reset mid-operation discards same-cycle writes and pend_set.
- Write:
  - Commits at the rising edge of clk when wr_en[k]=1.
  - Both ports hit the same address: port 1 data wins.
  - Address >= DEPTH: write ignored.
  - Address 0 with ZERO_REG=1: write ignored.
- Read: combinational, zero latency. Selection priority, highest first:
  1. Address 0 with ZERO_REG=1 -> 0.
  2. Address >= DEPTH -> 0.
  3. wr_en[1] and wr_addr[1]==rd_addr -> wr_data[1].
  4. wr_en[0] and wr_addr[0]==rd_addr -> wr_data[0].
  5. Otherwise the stored value.
- Scoreboard (one pending bit per register):
  - At the clock edge, wr_en[k] clears pending[wr_addr[k]].
  - pend_set sets pending[pend_addr].
  - Set and clear of the same address in the same cycle: set wins (a new producer supersedes the old one).
  - pend_set to address 0 (ZERO_REG=1) or to an address >= DEPTH: ignored.
  - pend_set to an already-pending register: stays pending, with no counter and no error.
- rd_ready[i] = 1 when any of the following holds, otherwise 0:
  - the register is not pending;
  - a bypass hit is active on port i;
  - the address is 0 with ZERO_REG=1;
  - the address is >= DEPTH.
- any_pending is registered-state derived: it reflects bits after the last edge, with no same-cycle bypass.
- Write port 1 priority applies to both the data and the pending-clear paths; a clear on either port clears the bit.
- No X propagation: unused slices of storage when DEPTH < 2**AW are never read.

Decomposition:
- Shared package (cpu_pkg): DATA_W=32, REG_CNT=32, REG_ZERO=0; the regfile_mp defaults reference these.
- One natural sub-module, regfile_rd_port: a single read port with bypass mux and ready logic, generated NUM_RD times.
- Storage, write logic and the scoreboard stay in the top module.

Test Plan:
1. Reset then read: assert rst, release; read addresses 0..31 -> rd_data = 0 and rd_ready = 1 on all; any_pending = 0.
2. Basic and same-address writes:
   - Write port 0 addr 5 = 0xDEADBEEF; next cycle read addr 5 -> 0xDEADBEEF.
   - Same cycle, port 0 addr 7 = 0x1 and port 1 addr 7 = 0x2 -> addr 7 reads 0x2 thereafter.
3. Bypass: same cycle, wr_en[0] addr 9 = 0x12345678 and rd_addr 9 -> rd_data = 0x12345678 combinationally, before the edge; value persists after the edge.
4. Zero register: write addr 0 = 0xFFFFFFFF and pend_set addr 0 -> addr 0 reads 0, rd_ready = 1, any_pending = 0.
5. Scoreboard:
   - pend_set addr 3 -> next cycle rd_ready = 0 and any_pending = 1 for addr 3.
   - Write addr 3 = 0xAA -> rd_ready = 1 during that cycle via bypass; pending cleared after the edge.
   - Same-cycle pend_set addr 4 plus write addr 4 -> addr 4 stays pending.
6. Async reset mid-operation: with addr 3 pending and addr 5 = 0x55, pulse rst between clock edges -> immediately all data = 0, rd_ready all 1, any_pending = 0; a write enabled during the reset cycle is not retained.
